// File: rtl/vga_sync_gen.sv
// Raster timing source for 640x480@60 VGA: pixel-enable divider, h/v counters, syncs.
// Optional `VGA_FRAME_TICK_EN enables the start-of-frame strobe; otherwise frame_tick is tied low.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pclk_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Half-open window test shared by both sync decoders.
  function automatic logic in_window(input logic [9:0] val,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

  logic [DIV_W-1:0] div_r;
  logic             pclk_en_s;
  logic [9:0]       h_cnt_r;
  logic [9:0]       v_cnt_r;
  logic [9:0]       h_nxt_s;
  logic [9:0]       v_nxt_s;
  logic             hsync_r;
  logic             vsync_r;
  logic             valid_r;

  assign pclk_en_s = (div_r == DIV_LAST);

  // Pixel-clock divider: counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
    end else if (pclk_en_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Next raster position; moves only on the pixel strobe.
  always_comb begin
    h_nxt_s = h_cnt_r;
    v_nxt_s = v_cnt_r;
    if (pclk_en_s) begin
      if (h_cnt_r == H_LAST) begin
        h_nxt_s = 10'd0;
        if (v_cnt_r == V_LAST) begin
          v_nxt_s = 10'd0;
        end else begin
          v_nxt_s = v_cnt_r + 10'd1;
        end
      end else begin
        h_nxt_s = h_cnt_r + 10'd1;
        v_nxt_s = v_cnt_r;
      end
    end else begin
      h_nxt_s = h_cnt_r;
      v_nxt_s = v_cnt_r;
    end
  end

  // Counters and decoded flags are all loaded from the next position so they stay coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= H_LAST;
      v_cnt_r <= V_LAST;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      h_cnt_r <= h_nxt_s;
      v_cnt_r <= v_nxt_s;
      hsync_r <= ~in_window(h_nxt_s, HS_START, HS_END);
      vsync_r <= ~in_window(v_nxt_s, VS_START, VS_END);
      valid_r <= (h_nxt_s < H_VIS) && (v_nxt_s < V_VIS);
    end
  end

`ifdef VGA_FRAME_TICK_EN
  logic frame_tick_r;

  // Strobe only on the advance that lands on (0,0), so it lasts a single clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= pclk_en_s && (h_nxt_s == 10'd0) && (v_nxt_s == 10'd0);
    end
  end

  assign frame_tick = frame_tick_r;
`else
  assign frame_tick = 1'b0;
`endif

  assign pclk_en = pclk_en_s;
  assign h_cnt   = h_cnt_r;
  assign v_cnt   = v_cnt_r;
  assign hsync   = hsync_r;
  assign vsync   = vsync_r;
  assign valid   = valid_r;

endmodule
